// File: rtl/multi_input_gate_pipe.sv
// Pipelined WIDTH-input OR/AND/XOR/NOR gate: input register, registered radix-4
// reduction tree, output register, saturating hit counter. Define STICKY_EN for the sticky hit flag.
module multi_input_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] gate_inputs_i,
    input  logic             clear_count_i,
    input  logic             clear_sticky_i,
    output logic             out_valid_o,
    output logic             gate_output_o,
    output logic [CNT_W-1:0] hit_count_o,
    output logic             sticky_out_o
);
    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,
        MODE_AND = 2'b01,
        MODE_XOR = 2'b10,
        MODE_NOR = 2'b11
    } mode_e;

    // Number of live nodes at tree level lvl (level 0 is the input register)
    function automatic int node_cnt(input int lvl);
        int n;
        n = WIDTH;
        for (int i = 0; i < 8; i++) begin
            if (i < lvl) n = (n + 3) / 4;
            else         n = n;
        end
        return n;
    endfunction

    function automatic int calc_levels(input int w);
        int n;
        int l;
        n = (w + 3) / 4;
        l = 1;
        for (int i = 0; i < 4; i++) begin
            if (n > 1) begin
                n = (n + 3) / 4;
                l = l + 1;
            end else begin
                n = n;
            end
        end
        return l;
    endfunction

    function automatic logic combine(input logic acc, input logic b, input mode_e m);
        case (m)
            MODE_AND: combine = acc & b;
            MODE_XOR: combine = acc ^ b;
            default:  combine = acc | b;
        endcase
    endfunction

    localparam int LEVELS = calc_levels(WIDTH);

    logic [63:0]      data_q  [0:LEVELS];
    mode_e            mode_q  [0:LEVELS];
    logic             valid_q [0:LEVELS];
    logic [63:0]      data_d  [1:LEVELS];
    logic             acc_s;
    logic             out_valid_q, out_valid_d;
    logic             gate_output_q, gate_output_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;

    // Tree levels: each node folds up to four bits; absent inputs take the mode's identity
    always_comb begin
        acc_s = 1'b0;
        for (int l = 1; l <= LEVELS; l++) begin
            data_d[l] = 64'd0;
            for (int j = 0; j < 16; j++) begin
                acc_s = (mode_q[l-1] == MODE_AND);
                for (int k = 0; k < 4; k++) begin
                    if ((4 * j + k) < node_cnt(l - 1)) acc_s = combine(acc_s, data_q[l-1][4*j+k], mode_q[l-1]);
                    else                               acc_s = acc_s;
                end
                if (j < node_cnt(l)) data_d[l][j] = acc_s;
                else                 data_d[l][j] = 1'b0;
            end
        end
    end

    // Output stage (NOR inversion, bubble zeroing) and saturating hit counter next state
    always_comb begin
        out_valid_d = valid_q[LEVELS];
        if (valid_q[LEVELS]) gate_output_d = data_q[LEVELS][0] ^ (mode_q[LEVELS] == MODE_NOR);
        else                 gate_output_d = 1'b0;
        hit_count_d = hit_count_q;
        if (clear_count_i) begin
            hit_count_d = '0;
        end else if (out_valid_q && gate_output_q && (hit_count_q != {CNT_W{1'b1}})) begin
            hit_count_d = hit_count_q + CNT_W'(1);
        end else begin
            hit_count_d = hit_count_q;
        end
    end

    // Pipeline registers: data, mode and valid advance together one level per cycle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int l = 0; l <= LEVELS; l++) begin
                valid_q[l] <= 1'b0;
                data_q[l]  <= 64'd0;
                mode_q[l]  <= MODE_OR;
            end
            out_valid_q   <= 1'b0;
            gate_output_q <= 1'b0;
            hit_count_q   <= '0;
        end else begin
            valid_q[0] <= in_valid_i;
            data_q[0]  <= 64'(gate_inputs_i);
            mode_q[0]  <= mode_e'(mode_i);
            for (int l = 1; l <= LEVELS; l++) begin
                valid_q[l] <= valid_q[l-1];
                data_q[l]  <= data_d[l];
                mode_q[l]  <= mode_q[l-1];
            end
            out_valid_q   <= out_valid_d;
            gate_output_q <= gate_output_d;
            hit_count_q   <= hit_count_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign gate_output_o = gate_output_q;
    assign hit_count_o   = hit_count_q;

`ifdef STICKY_EN
    logic sticky_q, sticky_d;

    // Sticky flag next state: a new hit outranks a clear in the same cycle
    always_comb begin
        sticky_d = sticky_q;
        if (out_valid_q && gate_output_q) sticky_d = 1'b1;
        else if (clear_sticky_i)          sticky_d = 1'b0;
        else                              sticky_d = sticky_q;
    end

    // Sticky flag register
    always_ff @(posedge clk_i) begin
        if (reset_i) sticky_q <= 1'b0;
        else         sticky_q <= sticky_d;
    end

    assign sticky_out_o = sticky_q;
`else
    logic unused_clear_sticky_s;
    assign unused_clear_sticky_s = clear_sticky_i;
    assign sticky_out_o          = 1'b0;
`endif

endmodule

// File: doc/multi_input_gate_pipe.md
# multi_input_gate_pipe

Parametrised, pipelined N-input logic gate: successor to the fixed three-input OR gate. Reduces a WIDTH-bit input vector to one bit under a per-beat selectable function (OR, AND, XOR, NOR) through a registered radix-4 reduction tree. It also keeps a saturating count of asserted results and an optional sticky hit flag. It sits between the pixel/feature logic and the neural-network front end wherever a wide "any/all/parity" decision is needed at full clock rate.

## Interface
- WIDTH, 8: number of gate inputs; legal range 1..64.
- CNT_W, 16: width of hitCount.
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- inValid  in  1  qualifies gateInputs/mode this cycle.
- mode  in  2  00 OR, 01 AND, 10 XOR, 11 NOR; sampled with data.
- gateInputs  in  WIDTH  operand vector.
- clearCount  in  1  synchronous clear of hitCount.
- clearSticky  in  1  synchronous clear of stickyOut.
- outValid  out  1  gateOutput holds a valid result.
- gateOutput  out  1  reduced result.
- hitCount  out  CNT_W  number of valid results equal to 1, saturating.
- stickyOut  out  1  set by any valid result equal to 1.

## Operation
- Stage 0: input register captures gateInputs, mode, inValid every cycle; no backpressure; one beat per cycle sustained.
- Tree: S = max(1, ceil(log4(WIDTH))) registered levels. Each node combines up to 4 bits. Missing node inputs are padded with the identity element: 0 for OR/XOR/NOR, 1 for AND.
- Mode and valid travel with their data through every level, so a mode change between consecutive beats affects only its own beat.
- NOR = inverted OR; inversion is applied only at the final level.
- Valid bubbles (inValid=0) propagate as outValid=0. gateOutput is don't-care when outValid=0, but the implementation holds it at 0.
- hitCount increments by 1 on each cycle with outValid=1 and gateOutput=1. It stops at 2^CNT_W-1.
- clearCount takes priority over an increment in the same cycle: the result is 0.
- stickyOut: see Configuration. If set and clear occur in the same cycle, set wins and the flag stays 1.

## Timing
- Latency: S+1 cycles from the clk edge sampling inValid=1 to outValid=1. WIDTH 1..4 → 2 cycles; 5..16 → 3 cycles; 17..64 → 4 cycles.
- Throughput: 1 result per cycle, in order, no gaps added.
- Reset (synchronous): all pipeline valids, gateOutput, outValid, hitCount, and stickyOut are 0 on the cycle after reset is sampled high.
- Reset mid-operation discards every in-flight beat; no outValid appears for beats accepted before reset.
- First beat accepted in the cycle reset deasserts produces a result S+1 cycles later.
- hitCount and stickyOut update one cycle after the outValid/gateOutput cycle that caused them; they are registered from the output stage.

## Configuration
- STICKY_EN defined: stickyOut is a register, set by outValid&gateOutput and cleared by clearSticky (set wins); it is cleared on reset.
- STICKY_EN undefined: the stickyOut port remains but is tied to 0, clearSticky is ignored, and no register is inferred.

## Test plan
- WIDTH=3, OR mode: walk all 8 input combinations (000..111), one per cycle. Required outputs, 2 cycles later: 0,1,1,1,1,1,1,1 back-to-back. hitCount = 7.
- WIDTH=8, mode changes each beat: 0xFF AND → 1; 0xFE AND → 0; 0x07 XOR → 1; 0x00 NOR → 1. Each result arrives 3 cycles after its input. Checks padding and per-beat mode.
- WIDTH=8, inValid pattern 1,0,1 with OR of 0x01: outValid pattern 1,0,1 with latency 3; gateOutput=0 in the bubble cycle.
- Reset asserted 1 cycle after 2 beats are accepted: no outValid for either beat. hitCount=0 and stickyOut=0 after reset.
- CNT_W=2, 5 consecutive 1-results: hitCount goes 1,2,3,3,3. Pulse clearCount together with another 1-result: hitCount becomes 0.
- STICKY_EN defined: one 1-result sets stickyOut. clearSticky alone clears it. clearSticky together with a 1-result leaves stickyOut at 1. STICKY_EN undefined: stickyOut stays 0 throughout.
